display_pipe: RTL and testbench
===============================

Name: display_pipe

Overview:
- Parametrised pixel output stage for the VGA path; sits between the ROM/colour source and the DAC/VGA pins.
- Delays the timing generator's counters, enables and syncs by a configurable pipeline latency so they align with the ROM read data.
- Selects the pixel source: ROM pass-through or one of three built-in test patterns.
- Registers RGB, syncs and data-enable at the output, with blanking outside the active area.

Parameters:
- CW, 8, bits per colour channel (1..10).
- PIPE_LAT, 2, ROM read latency in clk_25M cycles (0..7); delay applied to counters/enables/syncs.
- H_ACTIVE, 640, active pixels per line; must be a multiple of 8.
- V_ACTIVE, 480, active lines per frame.
- SYNC_IDLE, 1, idle level of o_hsync/o_vsync (1 = active-low syncs).

Ports:
- clk_25M  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- H_Count_Value  in  10  horizontal counter from the timing generator.
- V_Count_Value  in  10  vertical counter from the timing generator.
- enable_horizontal  in  1  horizontal active region.
- enable_vertical  in  1  vertical active region.
- hsync_in  in  1  raw hsync.
- vsync_in  in  1  raw vsync.
- colour_data  in  3*CW  ROM pixel, valid PIPE_LAT cycles after its counters; packing: [3CW-1:2CW] blue, [2CW-1:CW] green, [CW-1:0] red.
- mode  in  2  pixel source: 0 ROM, 1 colour bars, 2 grey ramp, 3 checkerboard.
- swap_rb  in  1  swap red/blue channels of the ROM source.
- o_red  out  CW  red output.
- o_green  out  CW  green output.
- o_blue  out  CW  blue output.
- o_hsync  out  1  aligned hsync.
- o_vsync  out  1  aligned vsync.
- o_de  out  1  aligned data-enable.
- o_frame_start  out  1  one-cycle pulse on the first active pixel of each frame.

Behaviour:
- Reset (rst_n=0 at a clk_25M edge): all delay stages cleared; RGB=0; o_de=0; o_frame_start=0; o_hsync=o_vsync=SYNC_IDLE. Shadow mode resets to 0, bar counters to 0.
- Delay line: H, V, de=(enable_horizontal&enable_vertical), hsync_in and vsync_in pass through PIPE_LAT register stages (H_d, V_d, de_d, hs_d, vs_d). PIPE_LAT=0 means a direct wire.
- Output register: one further stage.
  - Latency from counters/enables/syncs to outputs = PIPE_LAT+1.
  - Latency from colour_data to RGB = 1.
- Blanking: de_d=0 gives RGB=0, regardless of mode.
- Mode shadow: mode is sampled into mode_q only when de_d=1, H_d=0 and V_d=0 (frame start). A mid-frame mode change takes effect next frame.
  - o_frame_start asserts on the same output cycle as that pixel.
- Mode 0 (ROM): channels unpacked per the packing above. swap_rb=1 exchanges red and blue. swap_rb is not shadowed and takes effect immediately.
- Mode 1 (colour bars):
  - 8 bars of H_ACTIVE/8 pixels: white, yellow, cyan, green, magenta, red, blue, black.
  - Channel levels are all-ones or 0.
  - Bar index comes from a pixel counter and a 3-bit bar counter, both cleared when de_d=1 and H_d=0, advancing on de_d=1. Pixel counter wraps at H_ACTIVE/8-1 and increments the bar counter.
  - No division allowed.
- Mode 2 (grey ramp): R=G=B=H_d[9 -: CW].
- Mode 3 (checkerboard): H_d[5]^V_d[5] gives all-ones, otherwise 0 (32-pixel squares).
- Test patterns ignore swap_rb.
- rst_n deasserted mid-line: outputs stay blank until the delay line refills. No partial-bar artefacts: counters restart at the next H_d=0.

Optional Feature:
- Macro: DISPLAY_BORDER_EN.
- Defined: when de_d=1 and (H_d==0 | H_d==H_ACTIVE-1 | V_d==0 | V_d==V_ACTIVE-1), RGB = all-ones, overriding every mode.
- Undefined: no override, and no border logic is synthesised.

Test Plan:
- Reset: hold rst_n=0 for 4 cycles with active inputs → RGB=0, o_de=0, o_hsync=o_vsync=1, o_frame_start=0. After release, first o_de=1 appears exactly PIPE_LAT+1 cycles after the first de input.
- Latency and pass-through: PIPE_LAT=2, mode=0, colour_data=0xFF8040 with de=1 → 1 cycle later o_blue=0xFF, o_green=0x80, o_red=0x40. With swap_rb=1 → o_red=0xFF, o_blue=0x40.
- Colour bars: mode=1, full 640-pixel line.
  - Pixels 0–79 → (R,G,B)=(FF,FF,FF).
  - Pixels 80–159 → (FF,FF,00).
  - Pixels 560–639 → (00,00,00).
  - Blanking region → 0.
- Mode shadow: switch mode 0→3 at V=100 → output stays ROM data until the next frame start. o_frame_start pulses once per frame at H=0,V=0. Checkerboard at (H=32,V=0) = FF, at (H=32,V=32) = 0.
- Grey ramp and blanking: mode=2 at H=639 → RGB=0x9F each. With enable_vertical=0 → RGB=0 while syncs still propagate with PIPE_LAT+1 delay.
- With DISPLAY_BORDER_EN defined, mode=0, colour_data=0 → H=0, H=639, V=0 and V=479 give FF on all channels; interior is 0.

Source files
------------

// File: rtl/display_pipe_if.sv
// VGA output-stage bundle: timing-generator/ROM side inputs and DAC-side outputs.
// master drives the timing/colour side, slave is the pixel pipe.
interface display_pipe_if #(
  parameter int unsigned CW = 8
);
  logic [9:0]      H_Count_Value;
  logic [9:0]      V_Count_Value;
  logic            enable_horizontal;
  logic            enable_vertical;
  logic            hsync_in;
  logic            vsync_in;
  logic [3*CW-1:0] colour_data;
  logic [1:0]      mode;
  logic            swap_rb;

  logic [CW-1:0]   o_red;
  logic [CW-1:0]   o_green;
  logic [CW-1:0]   o_blue;
  logic            o_hsync;
  logic            o_vsync;
  logic            o_de;
  logic            o_frame_start;

  modport master (
    output H_Count_Value, V_Count_Value, enable_horizontal, enable_vertical,
           hsync_in, vsync_in, colour_data, mode, swap_rb,
    input  o_red, o_green, o_blue, o_hsync, o_vsync, o_de, o_frame_start
  );

  modport slave (
    input  H_Count_Value, V_Count_Value, enable_horizontal, enable_vertical,
           hsync_in, vsync_in, colour_data, mode, swap_rb,
    output o_red, o_green, o_blue, o_hsync, o_vsync, o_de, o_frame_start
  );
endinterface

// File: rtl/display_pipe.sv
// VGA pixel output stage: aligns timing with ROM data, selects ROM or test pattern, registers outputs.
// Optional white frame border when DISPLAY_BORDER_EN is defined.
module display_pipe #(
  parameter int unsigned CW        = 8,
  parameter int unsigned PIPE_LAT  = 2,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter bit          SYNC_IDLE = 1'b1
) (
  input logic          clk_25M,
  input logic          rst_n,
  display_pipe_if.slave vga
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned TAP_W = 2 * CNT_W + 3;
  localparam int unsigned BAR_W = H_ACTIVE >> 3;
  localparam logic [TAP_W-1:0] TAP_RST = {(2 * CNT_W + 1)'(0), SYNC_IDLE, SYNC_IDLE};

  if (CW < 1 || CW > 10 || PIPE_LAT > 7 || (H_ACTIVE % 8) != 0 || H_ACTIVE > 1024 ||
      V_ACTIVE == 0 || V_ACTIVE > 1024) begin : g_bad_param
    $error("display_pipe: parameter out of range");
  end

  logic [TAP_W-1:0] tap_in;
  logic [TAP_W-1:0] tap;

  assign tap_in = {vga.H_Count_Value, vga.V_Count_Value,
                   vga.enable_horizontal & vga.enable_vertical,
                   vga.hsync_in, vga.vsync_in};

  // Timing delay line matching the ROM read latency; sync stages park at their idle level
  if (PIPE_LAT == 0) begin : g_wire
    assign tap = tap_in;
  end else begin : g_pipe
    logic [TAP_W-1:0] stage [PIPE_LAT];

    always_ff @(posedge clk_25M) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(PIPE_LAT); i++) stage[i] <= TAP_RST;
      end else begin
        stage[0] <= tap_in;
        for (int i = 1; i < int'(PIPE_LAT); i++) stage[i] <= stage[i-1];
      end
    end

    assign tap = stage[PIPE_LAT-1];
  end

  logic [CNT_W-1:0] h_d;
  logic [CNT_W-1:0] v_d;
  logic             de_d;
  logic             hs_d;
  logic             vs_d;

  assign {h_d, v_d, de_d, hs_d, vs_d} = tap;

  logic h_zero;
  logic frame_start_c;
  logic [1:0] mode_q;
  logic [1:0] mode_eff;

  assign h_zero        = (h_d == '0);
  assign frame_start_c = de_d & h_zero & (v_d == '0);
  // The frame-start pixel already uses the newly sampled mode
  assign mode_eff      = frame_start_c ? vga.mode : mode_q;

  // Colour-bar position tracking without a divider
  logic [CNT_W-1:0] pix_cnt;
  logic [2:0]       bar_cnt;
  logic             bar_ok;
  logic [CNT_W-1:0] pix_cur;
  logic [CNT_W-1:0] pix_nxt;
  logic [2:0]       bar_cur;
  logic [2:0]       bar_nxt;
  logic             bar_live;

  always_comb begin
    pix_cur  = h_zero ? '0 : pix_cnt;
    bar_cur  = h_zero ? '0 : bar_cnt;
    bar_live = bar_ok | h_zero;
    if (pix_cur == CNT_W'(BAR_W - 1)) begin
      pix_nxt = '0;
      bar_nxt = bar_cur + 3'd1;
    end else begin
      pix_nxt = pix_cur + CNT_W'(1);
      bar_nxt = bar_cur;
    end
  end

  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      bar_cnt <= '0;
      bar_ok  <= 1'b0;
      mode_q  <= 2'd0;
    end else begin
      if (de_d) begin
        pix_cnt <= pix_nxt;
        bar_cnt <= bar_nxt;
        if (h_zero) bar_ok <= 1'b1;
      end
      if (frame_start_c) mode_q <= vga.mode;
    end
  end

  logic [CW-1:0] red_c;
  logic [CW-1:0] green_c;
  logic [CW-1:0] blue_c;

  // Pixel source select; blank outside the active area
  always_comb begin
    red_c   = '0;
    green_c = '0;
    blue_c  = '0;
    if (de_d) begin
      case (mode_eff)
        2'd0: begin
          red_c   = vga.colour_data[CW-1:0];
          green_c = vga.colour_data[2*CW-1:CW];
          blue_c  = vga.colour_data[3*CW-1:2*CW];
          if (vga.swap_rb) begin
            red_c  = vga.colour_data[3*CW-1:2*CW];
            blue_c = vga.colour_data[CW-1:0];
          end
        end
        2'd1: begin
          // Bars until the first line start after reset would be misaligned, so hold black
          if (bar_live) begin
            red_c   = {CW{~bar_cur[1]}};
            green_c = {CW{~bar_cur[2]}};
            blue_c  = {CW{~bar_cur[0]}};
          end
        end
        2'd2: begin
          red_c   = h_d[9 -: CW];
          green_c = h_d[9 -: CW];
          blue_c  = h_d[9 -: CW];
        end
        default: begin
          red_c   = {CW{h_d[5] ^ v_d[5]}};
          green_c = {CW{h_d[5] ^ v_d[5]}};
          blue_c  = {CW{h_d[5] ^ v_d[5]}};
        end
      endcase
`ifdef DISPLAY_BORDER_EN
      if (h_zero || h_d == CNT_W'(H_ACTIVE - 1) || v_d == '0 || v_d == CNT_W'(V_ACTIVE - 1)) begin
        red_c   = '1;
        green_c = '1;
        blue_c  = '1;
      end
`else
`endif
    end
  end

  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      vga.o_red         <= '0;
      vga.o_green       <= '0;
      vga.o_blue        <= '0;
      vga.o_hsync       <= SYNC_IDLE;
      vga.o_vsync       <= SYNC_IDLE;
      vga.o_de          <= 1'b0;
      vga.o_frame_start <= 1'b0;
    end else begin
      vga.o_red         <= red_c;
      vga.o_green       <= green_c;
      vga.o_blue        <= blue_c;
      vga.o_hsync       <= hs_d;
      vga.o_vsync       <= vs_d;
      vga.o_de          <= de_d;
      vga.o_frame_start <= frame_start_c;
    end
  end

endmodule

// File: tb/tb_display_pipe.sv
// Scoreboard bench for display_pipe: stimulus pushes expected output per cycle, a monitor pops and compares.
// Border expectations follow DISPLAY_BORDER_EN when defined.
module tb_display_pipe;

  localparam int unsigned CW    = 8;
  localparam int unsigned LAT   = 2;
  localparam int unsigned H_ACT = 640;
  localparam int unsigned V_ACT = 480;
  localparam int unsigned H_TOT = 656;

  logic clk_25M = 1'b0;
  logic rst_n   = 1'b0;

  display_pipe_if #(.CW(CW)) bus ();

  display_pipe #(
    .CW(CW), .PIPE_LAT(LAT), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .SYNC_IDLE(1'b1)
  ) dut (
    .clk_25M(clk_25M),
    .rst_n  (rst_n),
    .vga    (bus)
  );

  always #20 clk_25M = ~clk_25M;

  typedef struct {
    logic        rst;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        eh;
    logic        ev;
    logic        hs;
    logic        vs;
    logic [23:0] col;
    logic [1:0]  mode;
    logic        swap;
  } stim_t;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       de;
    logic       hs;
    logic       vs;
  } tim_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    int         phase;
  } exp_t;

  // Bar colours as {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  localparam tim_t TIM_RST = '{h: 10'd0, v: 10'd0, de: 1'b0, hs: 1'b1, vs: 1'b1};

  exp_t exp_q[$];
  tim_t hist[$];
  logic [1:0] msh = 2'd0;
  int   phase = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cyc(input stim_t s);
    tim_t d;
    tim_t cur;
    exp_t e;
    logic [1:0]  m;
    logic [23:0] rgb;
    @(negedge clk_25M);
    rst_n                 = s.rst;
    bus.H_Count_Value     = s.h;
    bus.V_Count_Value     = s.v;
    bus.enable_horizontal = s.eh;
    bus.enable_vertical   = s.ev;
    bus.hsync_in          = s.hs;
    bus.vsync_in          = s.vs;
    bus.colour_data       = s.col;
    bus.mode              = s.mode;
    bus.swap_rb           = s.swap;

    e.phase = phase;
    if (!s.rst) begin
      e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
      e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.fs = 1'b0;
      msh = 2'd0;
      hist.delete();
      for (int i = 0; i < int'(LAT); i++) hist.push_back(TIM_RST);
    end else begin
      d   = hist.pop_front();
      cur = '{h: s.h, v: s.v, de: s.eh & s.ev, hs: s.hs, vs: s.vs};
      hist.push_back(cur);
      e.de = d.de;
      e.hs = d.hs;
      e.vs = d.vs;
      e.fs = d.de && d.h == 10'd0 && d.v == 10'd0;
      if (e.fs) msh = s.mode;
      m   = msh;
      rgb = 24'h000000;
      if (d.de) begin
        case (m)
          2'd0:    rgb = s.swap ? {s.col[23:16], s.col[15:8], s.col[7:0]}
                                : {s.col[7:0], s.col[15:8], s.col[23:16]};
          2'd1:    rgb = BARS[int'(d.h) / 80];
          2'd2:    rgb = {d.h[9:2], d.h[9:2], d.h[9:2]};
          default: rgb = (d.h[5] ^ d.v[5]) ? 24'hFFFFFF : 24'h000000;
        endcase
`ifdef DISPLAY_BORDER_EN
        if (d.h == 10'd0 || d.h == 10'd639 || d.v == 10'd0 || d.v == 10'd479) rgb = 24'hFFFFFF;
`endif
      end
      e.r = rgb[23:16];
      e.g = rgb[15:8];
      e.b = rgb[7:0];
    end
    exp_q.push_back(e);
  endtask

  task automatic line(input logic [9:0] v, input logic ev, input logic vs,
                      input logic [1:0] mode, input logic swap, input int ph);
    stim_t s;
    phase = ph;
    for (int h = 0; h < int'(H_TOT); h++) begin
      s.rst  = 1'b1;
      s.h    = 10'(h);
      s.v    = v;
      s.eh   = (h < int'(H_ACT));
      s.ev   = ev;
      s.hs   = !(h >= 648 && h < 652);
      s.vs   = vs;
      s.col  = {8'(h * 3), 8'(h + int'(v)), 8'(h ^ int'(v))};
      s.mode = mode;
      s.swap = swap;
      cyc(s);
    end
  endtask

  // Monitor: one expected entry per output cycle, sampled after the edge settles
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_25M);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.o_red !== e.r || bus.o_green !== e.g || bus.o_blue !== e.b ||
            bus.o_hsync !== e.hs || bus.o_vsync !== e.vs || bus.o_de !== e.de ||
            bus.o_frame_start !== e.fs) begin
          n_bad++;
          $display("FAIL pix phase=%0d got rgb=%h_%h_%h hs=%b vs=%b de=%b fs=%b want rgb=%h_%h_%h hs=%b vs=%b de=%b fs=%b",
                   e.phase, bus.o_red, bus.o_green, bus.o_blue, bus.o_hsync, bus.o_vsync,
                   bus.o_de, bus.o_frame_start, e.r, e.g, e.b, e.hs, e.vs, e.de, e.fs);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    for (int i = 0; i < int'(LAT); i++) hist.push_back(TIM_RST);

    // Reset with live active inputs
    phase = 1;
    for (int i = 0; i < 4; i++) begin
      s = '{rst: 1'b0, h: 10'(5 + i), v: 10'd10, eh: 1'b1, ev: 1'b1, hs: 1'(i % 2),
            vs: 1'b0, col: 24'h123456, mode: 2'd1, swap: 1'b0};
      cyc(s);
    end

    // Release: latency fill then ROM pass-through, plain and swapped
    phase = 2;
    for (int i = 0; i < 8; i++) begin
      s = '{rst: 1'b1, h: 10'(9 + i), v: 10'd10, eh: 1'b1, ev: 1'b1, hs: 1'b1,
            vs: 1'b1, col: 24'hFF8040, mode: 2'd0, swap: (i >= 5)};
      cyc(s);
    end

    line(10'd11,  1'b1, 1'b1, 2'd0, 1'b0, 3);  // ROM line
    line(10'd0,   1'b1, 1'b1, 2'd1, 1'b0, 4);  // frame start into colour bars
    line(10'd1,   1'b1, 1'b1, 2'd2, 1'b0, 5);  // mid-frame mode change: still bars
    line(10'd0,   1'b1, 1'b1, 2'd2, 1'b0, 6);  // grey ramp frame
    line(10'd0,   1'b1, 1'b1, 2'd0, 1'b0, 7);  // back to ROM
    line(10'd32,  1'b1, 1'b1, 2'd0, 1'b1, 8);  // ROM with red/blue swap
    line(10'd100, 1'b1, 1'b1, 2'd3, 1'b1, 9);  // mode 3 requested mid-frame: ROM stays
    line(10'd479, 1'b1, 1'b1, 2'd3, 1'b0, 10);
    line(10'd480, 1'b0, 1'b0, 2'd2, 1'b0, 11); // vertical blanking, syncs keep moving
    line(10'd0,   1'b1, 1'b1, 2'd3, 1'b1, 12); // checkerboard frame
    line(10'd32,  1'b1, 1'b1, 2'd0, 1'b0, 13);

    phase = 14;
    for (int i = 0; i < 4; i++) begin
      s = '{rst: 1'b1, h: 10'(700 + i), v: 10'd40, eh: 1'b0, ev: 1'b1, hs: 1'b1,
            vs: 1'b1, col: 24'h000000, mode: 2'd0, swap: 1'b0};
      cyc(s);
    end
    @(posedge clk_25M);
    @(posedge clk_25M);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
